// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {LOOP = 1'b0, ONESHOT = 1'b1} mode_t;
  localparam int CFG_RATE = 0;
  localparam int CFG_END  = 1;
  localparam int CFG_MODE = 2;
endpackage

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: clock-enable tick every 2**rate enabled cycles
module rate_tick_gen #(
  parameter int RATE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);
  localparam int CW = 2**RATE_W - 1;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_lim;
  // the largest rate wraps the shift to zero, so the subtraction still yields all ones
  assign w_lim = (CW'(1) << rate) - CW'(1);
  assign tick  = en && (r_cnt == w_lim);
  // divider count: cleared on request or tick, advances while enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (clr || tick) ? '0 : en ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: steps a program counter through an internal program RAM
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int RATE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              save_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              valid,
  output logic              busy,
  output logic              done
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  state_t            r_state, w_state_nxt;
  mode_t             r_mode;
  logic [RATE_W-1:0] r_rate;
  logic [ADDR_W-1:0] r_end, r_next_pc, r_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              w_run, w_start, w_last, w_tick, w_clr, w_en, w_cfg_we;
  assign w_run    = r_state == RUN;
  assign w_start  = start && !stop;
  assign w_last   = r_next_pc == r_end;
  assign w_en     = w_run && !start && !stop;
  assign w_clr    = !w_en;
  assign w_cfg_we = !sel && !save_n && !w_run;
  rate_tick_gen #(.RATE_W(RATE_W)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .en   (w_en),
    .rate (r_rate),
    .tick (w_tick)
  );
  // program RAM: written any time, never reset; reads see the pre-write word
  always_ff @(posedge clk)
    if (sel && !save_n) r_mem[wr_addr] <= data;
  // configuration registers, frozen while running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rate <= '0;
      r_end  <= '1;
      r_mode <= LOOP;
    end else if (w_cfg_we) begin
      if (wr_addr == ADDR_W'(CFG_RATE)) r_rate <= data[RATE_W-1:0];
      if (wr_addr == ADDR_W'(CFG_END))  r_end  <= ADDR_W'(data);
      if (wr_addr == ADDR_W'(CFG_MODE)) r_mode <= mode_t'(data[0]);
    end
  // next state: stop wins, then start, then one-shot completion on the last step
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = stop ? IDLE : w_start ? RUN :
                  (w_tick && w_last && r_mode == ONESHOT) ? DONE : r_state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // program counter, fetched instruction and step pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_next_pc <= '0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_tick;
      if (w_start) r_next_pc <= '0;
      else if (w_tick) r_next_pc <= w_last ? '0 : r_next_pc + 1'b1;
      if (w_tick) begin
        r_pc    <= r_next_pc;
        r_instr <= r_mem[r_next_pc];
      end
    end
  assign instr = r_instr;
  assign pc    = r_pc;
  assign valid = r_valid;
  assign busy  = w_run;
  assign done  = r_state == DONE;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, sel, save_n, start, stop;
  logic [3:0] data, wr_addr, instr, pc;
  logic       valid, busy, done;
  int         checks = 0;
  int         failures = 0;

  instr_sequencer #(.DATA_W(4), .ADDR_W(4), .RATE_W(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .save_n (save_n),
    .data   (data),
    .wr_addr(wr_addr),
    .start  (start),
    .stop   (stop),
    .instr  (instr),
    .pc     (pc),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [3:0] val);
    sel = 1'b0; save_n = 1'b0; wr_addr = idx; data = val;
    step();
    save_n = 1'b1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [3:0] val);
    sel = 1'b1; save_n = 1'b0; wr_addr = a; data = val;
    step();
    save_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_chk(input int gap, input logic [3:0] p, input logic [3:0] ins);
    for (int i = 1; i < gap; i++) begin
      step();
      chk("gap_valid", valid, 0);
    end
    step();
    chk("valid", valid, 1);
    chk("pc", pc, p);
    chk("instr", instr, ins);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; save_n = 1'b1; data = '0; wr_addr = '0;
    start = 1'b0; stop = 1'b0;
    #2;
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    // loop over four words at full rate, then reset mid-run
    prog(0, 4'hA); prog(1, 4'hB); prog(2, 4'hC); prog(3, 4'hD);
    cfg(0, 0); cfg(1, 3); cfg(2, 0);
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_valid", valid, 0);
    run_chk(1, 0, 4'hA); run_chk(1, 1, 4'hB); run_chk(1, 2, 4'hC);
    run_chk(1, 3, 4'hD); run_chk(1, 0, 4'hA); run_chk(1, 1, 4'hB);
    rst_n = 1'b0;
    #1;
    chk("arst_instr", instr, 0);
    chk("arst_pc", pc, 0);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    #1;
    rst_n = 1'b1;
    step();
    // one-shot at rate 2
    cfg(0, 2); cfg(1, 2); cfg(2, 1);
    pulse_start();
    run_chk(4, 0, 4'hA); run_chk(4, 1, 4'hB); run_chk(4, 2, 4'hC);
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    step(); step();
    chk("os_hold_instr", instr, 4'hC);
    chk("os_hold_pc", pc, 2);
    chk("os_hold_valid", valid, 0);
    chk("os_hold_done", done, 1);
    // stop on a tick cycle, then restart
    cfg(0, 1); cfg(1, 3); cfg(2, 0);
    pulse_start();
    run_chk(2, 0, 4'hA); run_chk(2, 1, 4'hB);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_valid", valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_instr", instr, 4'hB);
    chk("stop_pc", pc, 1);
    step(); step();
    chk("idle_valid", valid, 0);
    chk("idle_busy", busy, 0);
    pulse_start();
    run_chk(2, 0, 4'hA);
    // config lockout and live program write
    cfg(0, 3);
    chk("lock_valid", valid, 0);
    run_chk(1, 1, 4'hB);
    prog(1, 4'hF);
    chk("live_gap_valid", valid, 0);
    run_chk(1, 2, 4'hC); run_chk(2, 3, 4'hD); run_chk(2, 0, 4'hA); run_chk(2, 1, 4'hF);
    // simultaneous start and stop
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_done", done, 0);
    chk("ss_valid", valid, 0);
    step();
    chk("ss_idle_valid", valid, 0);
    // end address zero repeats word 0
    cfg(0, 1); cfg(1, 0);
    pulse_start();
    run_chk(2, 0, 4'hA); run_chk(2, 0, 4'hA); run_chk(2, 0, 4'hA);
    // full-depth wrap at rate 0
    stop = 1'b1;
    step();
    stop = 1'b0;
    cfg(0, 0); cfg(1, 15);
    for (int i = 0; i < 16; i++) prog(4'(i), 4'(15 - i));
    pulse_start();
    for (int i = 0; i < 20; i++) run_chk(1, 4'(i % 16), 4'(15 - (i % 16)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
